mem_bus_arbiter: RTL and testbench

//  Shares a single memory bus (addr/data two-phase handshake) between the IF1 fetch port and the MM1 data port.

---
 rtl/mem_bus_arbiter.sv | 243 ++++++++++++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter
//   Shares one two-phase (address / data) memory bus between the fetch port
//   (inst_*) and the data port (data_*). Exactly one bus transaction is
//   outstanding at a time; the response is routed back to whichever port owns
//   it. A flush (inst_cancel) discards a pending or in-flight fetch response
//   while still letting the bus transaction run to completion.
//
// Ports
//   clk, rst                      clock (rising edge), synchronous active-high reset
//   inst_req/inst_addr/inst_cancel  fetch request, address, flush
//   inst_ack/inst_rvalid/inst_rdata  fetch accept pulse, response pulse, data
//   data_req/data_wr/data_addr/data_wdata/data_wstrb  data request and payload
//   data_ack/data_rvalid/data_rdata  data accept pulse, response pulse, data
//   bus_req/bus_wr/bus_addr/bus_wdata/bus_wstrb  bus address phase + payload
//   bus_addr_ok/bus_data_ok/bus_rdata  bus address accept, data done, read data
//   arb_busy                      transaction in progress (state != IDLE)
//
// Build option
//   ARB_STARVE_GUARD_EN : after STARVE_LIMIT consecutive data grants made while
//   a fetch was waiting, the next grant goes to the fetch port. Without it the
//   data port has strict priority.
//
// States
//   IDLE | no transaction; grant made combinationally from requests
//   ADDR | bus_req asserted with latched payload until bus_addr_ok
//   RESP | waiting for bus_data_ok, then respond to owner and return to IDLE

module mem_bus_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  input  logic        inst_cancel,
  output logic        inst_ack,
  output logic        inst_rvalid,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  input  logic [3:0]  data_wstrb,
  output logic        data_ack,
  output logic        data_rvalid,
  output logic [31:0] data_rdata,
  output logic        bus_req,
  output logic        bus_wr,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_wstrb,
  input  logic        bus_addr_ok,
  input  logic        bus_data_ok,
  input  logic [31:0] bus_rdata,
  output logic        arb_busy
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ADDR = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  localparam logic OWN_DATA = 1'b0;
  localparam logic OWN_INST = 1'b1;

  logic [1:0]  state_q, state_d;
  logic        owner_q, owner_d;
  logic        drop_q, drop_d;
  logic        bus_wr_q, bus_wr_d;
  logic [31:0] bus_addr_q, bus_addr_d;
  logic [31:0] bus_wdata_q, bus_wdata_d;
  logic [3:0]  bus_wstrb_q, bus_wstrb_d;
  logic        inst_rvalid_q, inst_rvalid_d;
  logic        data_rvalid_q, data_rvalid_d;
  logic [31:0] inst_rdata_q, inst_rdata_d;
  logic [31:0] data_rdata_q, data_rdata_d;

  logic        grant_inst;
  logic        grant_data;
  logic        inst_eligible;

  // A fetch being flushed in the same cycle is not worth starting.
  assign inst_eligible = inst_req & ~inst_cancel;

`ifdef ARB_STARVE_GUARD_EN
  localparam logic [2:0] STARVE_LIM3 = 3'(STARVE_LIMIT);

  logic [2:0] starve_cnt_q, starve_cnt_d;
  logic       force_inst;

  assign force_inst = (starve_cnt_q == STARVE_LIM3);

  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (state_q == ST_IDLE) begin
      if (grant_inst || !inst_req) begin
        starve_cnt_d = 3'd0;
      end else if (grant_data && !inst_cancel && (starve_cnt_q != STARVE_LIM3)) begin
        starve_cnt_d = starve_cnt_q + 3'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt_q <= 3'd0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
    end
  end
`endif

  // Grant is only possible in IDLE; masked during reset so no ack pulse is
  // issued for a request that the reset is about to discard.
  always_comb begin
    grant_inst = 1'b0;
    grant_data = 1'b0;
    if ((state_q == ST_IDLE) && !rst) begin
`ifdef ARB_STARVE_GUARD_EN
      if (force_inst && inst_eligible) begin
        grant_inst = 1'b1;
      end else if (data_req) begin
        grant_data = 1'b1;
      end else if (inst_eligible) begin
        grant_inst = 1'b1;
      end
`else
      if (data_req) begin
        grant_data = 1'b1;
      end else if (inst_eligible) begin
        grant_inst = 1'b1;
      end
`endif
    end
  end

  always_comb begin
    state_d       = state_q;
    owner_d       = owner_q;
    drop_d        = drop_q;
    bus_wr_d      = bus_wr_q;
    bus_addr_d    = bus_addr_q;
    bus_wdata_d   = bus_wdata_q;
    bus_wstrb_d   = bus_wstrb_q;
    inst_rvalid_d = 1'b0;
    data_rvalid_d = 1'b0;
    inst_rdata_d  = inst_rdata_q;
    data_rdata_d  = data_rdata_q;

    case (state_q)
      ST_IDLE: begin
        drop_d = 1'b0;
        if (grant_data) begin
          owner_d     = OWN_DATA;
          bus_wr_d    = data_wr;
          bus_addr_d  = data_addr;
          bus_wdata_d = data_wdata;
          bus_wstrb_d = data_wstrb;
          state_d     = ST_ADDR;
        end else if (grant_inst) begin
          owner_d     = OWN_INST;
          bus_wr_d    = 1'b0;
          bus_addr_d  = inst_addr;
          bus_wdata_d = 32'h0;
          bus_wstrb_d = 4'h0;
          state_d     = ST_ADDR;
        end
      end

      ST_ADDR: begin
        if ((owner_q == OWN_INST) && inst_cancel) begin
          drop_d = 1'b1;
        end
        // A data_ok arriving with addr_ok belongs to no phase yet; ignore it.
        if (bus_addr_ok) begin
          state_d = ST_RESP;
        end
      end

      ST_RESP: begin
        if ((owner_q == OWN_INST) && inst_cancel) begin
          drop_d = 1'b1;
        end
        if (bus_data_ok) begin
          state_d = ST_IDLE;
          drop_d  = 1'b0;
          if (owner_q == OWN_DATA) begin
            data_rvalid_d = 1'b1;
            data_rdata_d  = bus_rdata;
          end else if (!(drop_q || inst_cancel)) begin
            inst_rvalid_d = 1'b1;
            inst_rdata_d  = bus_rdata;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      owner_q       <= OWN_DATA;
      drop_q        <= 1'b0;
      bus_wr_q      <= 1'b0;
      bus_addr_q    <= 32'h0;
      bus_wdata_q   <= 32'h0;
      bus_wstrb_q   <= 4'h0;
      inst_rvalid_q <= 1'b0;
      data_rvalid_q <= 1'b0;
      inst_rdata_q  <= 32'h0;
      data_rdata_q  <= 32'h0;
    end else begin
      state_q       <= state_d;
      owner_q       <= owner_d;
      drop_q        <= drop_d;
      bus_wr_q      <= bus_wr_d;
      bus_addr_q    <= bus_addr_d;
      bus_wdata_q   <= bus_wdata_d;
      bus_wstrb_q   <= bus_wstrb_d;
      inst_rvalid_q <= inst_rvalid_d;
      data_rvalid_q <= data_rvalid_d;
      inst_rdata_q  <= inst_rdata_d;
      data_rdata_q  <= data_rdata_d;
    end
  end

  assign inst_ack    = grant_inst;
  assign data_ack    = grant_data;
  assign inst_rvalid = inst_rvalid_q;
  assign inst_rdata  = inst_rdata_q;
  assign data_rvalid = data_rvalid_q;
  assign data_rdata  = data_rdata_q;
  assign bus_req     = (state_q == ST_ADDR);
  assign bus_wr      = bus_wr_q;
  assign bus_addr    = bus_addr_q;
  assign bus_wdata   = bus_wdata_q;
  assign bus_wstrb   = bus_wstrb_q;
  assign arb_busy    = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mem_bus_arbiter.sv
module tb_mem_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        inst_req, inst_cancel;
  logic [31:0] inst_addr;
  logic        inst_ack, inst_rvalid;
  logic [31:0] inst_rdata;
  logic        data_req, data_wr;
  logic [31:0] data_addr, data_wdata;
  logic [3:0]  data_wstrb;
  logic        data_ack, data_rvalid;
  logic [31:0] data_rdata;
  logic        bus_req, bus_wr;
  logic [31:0] bus_addr, bus_wdata;
  logic [3:0]  bus_wstrb;
  logic        bus_addr_ok, bus_data_ok;
  logic [31:0] bus_rdata;
  logic        arb_busy;

  mem_bus_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk(clk), .rst(rst),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_cancel(inst_cancel),
    .inst_ack(inst_ack), .inst_rvalid(inst_rvalid), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_wstrb(data_wstrb),
    .data_ack(data_ack), .data_rvalid(data_rvalid), .data_rdata(data_rdata),
    .bus_req(bus_req), .bus_wr(bus_wr), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_wstrb(bus_wstrb),
    .bus_addr_ok(bus_addr_ok), .bus_data_ok(bus_data_ok), .bus_rdata(bus_rdata),
    .arb_busy(arb_busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    bit          is_inst;
    bit          wr;
    logic [31:0] rdata;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  typedef struct {
    bit          is_inst;
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] rdata;
    int          addr_dly;
    int          data_dly;
    bit          cancel;
    bit          dok_early;
    bit          do_rst;
  } vec_t;

  vec_t vecs[8];

  logic        exp_wr;
  logic [31:0] exp_addr, exp_wdata;
  logic [3:0]  exp_wstrb;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic set_exp_payload(input bit is_inst, input bit wr, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic [3:0] wstrb);
    exp_wr    = is_inst ? 1'b0 : wr;
    exp_addr  = addr;
    exp_wdata = is_inst ? 32'h0 : wdata;
    exp_wstrb = is_inst ? 4'h0 : wstrb;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_ctrl"}, {21'h0, inst_ack, data_ack, inst_rvalid, data_rvalid,
                         bus_req, bus_wr, arb_busy, bus_wstrb}, 32'h0);
    chk({tag, "_inst_rdata"}, inst_rdata, 32'h0);
    chk({tag, "_data_rdata"}, data_rdata, 32'h0);
    chk({tag, "_bus_addr"}, bus_addr, 32'h0);
    chk({tag, "_bus_wdata"}, bus_wdata, 32'h0);
  endtask

  // Bus slave: entered at the negedge of the first ADDR cycle, returns at the
  // negedge of the cycle in which the response pulse is visible.
  task automatic slave(input bit is_inst, input bit wr, input logic [31:0] rdata,
                       input int addr_dly, input int data_dly, input bit cancel,
                       input bit dok_early, input bit do_rst);
    for (int i = 0; i <= addr_dly; i++) begin
      if (i > 0) @(negedge clk);
      bus_addr_ok = (i == addr_dly);
      bus_data_ok = (i == addr_dly) && dok_early;
      bus_rdata   = 32'hFFFF_FFFF;
      #1;
      chk("bus_req_addr", {31'h0, bus_req}, 32'h1);
    end
    @(negedge clk);
    bus_addr_ok = 1'b0;
    bus_data_ok = 1'b0;
    if (do_rst) begin
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      return;
    end
    for (int i = 0; i <= data_dly; i++) begin
      if (i > 0) @(negedge clk);
      inst_cancel = cancel && (i == 0);
      bus_data_ok = (i == data_dly);
      if (i == data_dly) begin
        bus_rdata = rdata;
        if (!(cancel && is_inst)) sb.push_back('{is_inst, wr, rdata, cyc + 1});
      end
      #1;
      chk("bus_req_resp", {31'h0, bus_req}, 32'h0);
    end
    @(negedge clk);
    bus_data_ok = 1'b0;
    inst_cancel = 1'b0;
  endtask

  task automatic run_txn(input vec_t v);
    int waited;
    @(negedge clk);
    if (v.is_inst) begin
      inst_req  = 1'b1;
      inst_addr = v.addr;
    end else begin
      data_req   = 1'b1;
      data_wr    = v.wr;
      data_addr  = v.addr;
      data_wdata = v.wdata;
      data_wstrb = v.wstrb;
    end
    waited = 0;
    #1;
    while (!(v.is_inst ? inst_ack : data_ack) && waited < 20) begin
      @(negedge clk);
      #1;
      waited++;
    end
    chk("ack_wait", waited, 0);
    set_exp_payload(v.is_inst, v.wr, v.addr, v.wdata, v.wstrb);
    @(negedge clk);
    inst_req = 1'b0;
    data_req = 1'b0;
    slave(v.is_inst, v.wr, v.rdata, v.addr_dly, v.data_dly, v.cancel, v.dok_early, v.do_rst);
    #1;
    if (v.do_rst) check_zero("mid_rst");
    else chk("idle_after", {31'h0, arb_busy}, 32'h0);
  endtask

  // Response / protocol monitor.
  always @(negedge clk) begin
    #1;
    if (inst_ack || data_ack) chk("dual_ack", {31'h0, inst_ack & data_ack}, 32'h0);
    if (inst_rvalid || data_rvalid) begin
      chk("dual_rvalid", {31'h0, inst_rvalid & data_rvalid}, 32'h0);
      if (sb.size() == 0) begin
        chk("unexp_rvalid", {30'h0, inst_rvalid, data_rvalid}, 32'h0);
      end else begin
        mon_e = sb.pop_front();
        chk("rv_owner", {31'h0, inst_rvalid}, {31'h0, mon_e.is_inst});
        chk("rv_cycle", cyc, mon_e.cyc);
        if (!mon_e.wr) chk("rv_rdata", inst_rvalid ? inst_rdata : data_rdata, mon_e.rdata);
      end
    end
    if (bus_req) begin
      chk("bus_addr", bus_addr, exp_addr);
      chk("bus_wdata", bus_wdata, exp_wdata);
      chk("bus_wr_wstrb", {27'h0, bus_wr, bus_wstrb}, {27'h0, exp_wr, exp_wstrb});
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit exp_i;

    //          inst wr addr          wdata         wstrb  rdata         ad dd cn de rs
    vecs[0] = '{0, 0, 32'h0000_1000, 32'h0,        4'h0,  32'hDEAD_BEEF, 0, 0, 0, 0, 0};
    vecs[1] = '{1, 0, 32'h1C00_0000, 32'h0,        4'h0,  32'hAAAA_0001, 1, 2, 1, 0, 0};
    vecs[2] = '{1, 0, 32'h1C00_0004, 32'h0,        4'h0,  32'hCAFE_F00D, 0, 1, 0, 0, 0};
    vecs[3] = '{0, 1, 32'h0000_2000, 32'h1234_5678, 4'h3, 32'h0000_0BAD, 5, 1, 0, 0, 0};
    vecs[4] = '{0, 0, 32'h0000_3000, 32'h0,        4'h0,  32'h0BAD_F00D, 0, 2, 0, 1, 0};
    vecs[5] = '{1, 0, 32'h1C00_0100, 32'h0,        4'h0,  32'h0,         0, 0, 0, 0, 1};
    vecs[6] = '{1, 0, 32'h1C00_0200, 32'h0,        4'h0,  32'h55AA_33CC, 2, 0, 0, 0, 0};
    vecs[7] = '{0, 0, 32'h0000_4000, 32'h0,        4'h0,  32'h1357_9BDF, 0, 1, 1, 0, 0};

    rst = 1'b1;
    inst_req = 1'b0; inst_addr = 32'h0; inst_cancel = 1'b0;
    data_req = 1'b0; data_wr = 1'b0; data_addr = 32'h0; data_wdata = 32'h0; data_wstrb = 4'h0;
    bus_addr_ok = 1'b0; bus_data_ok = 1'b0; bus_rdata = 32'h0;
    exp_wr = 1'b0; exp_addr = 32'h0; exp_wdata = 32'h0; exp_wstrb = 4'h0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check_zero("reset");

    for (int i = 0; i < 8; i++) run_txn(vecs[i]);

    // Both ports requesting together: data first, fetch granted in the
    // same cycle the data response appears.
    @(negedge clk);
    data_req = 1'b1; data_wr = 1'b0; data_addr = 32'h0000_5000;
    inst_req = 1'b1; inst_addr = 32'h1C00_0300;
    #1;
    chk("both_data_ack", {31'h0, data_ack}, 32'h1);
    chk("both_inst_ack", {31'h0, inst_ack}, 32'h0);
    set_exp_payload(0, 0, 32'h0000_5000, data_wdata, data_wstrb);
    @(negedge clk);
    data_req = 1'b0;
    slave(0, 0, 32'h1111_2222, 0, 0, 0, 0, 0);
    #1;
    chk("inst_ack_at_rvalid", {31'h0, inst_ack}, 32'h1);
    set_exp_payload(1, 0, 32'h1C00_0300, 32'h0, 4'h0);
    @(negedge clk);
    inst_req = 1'b0;
    slave(1, 0, 32'h3333_4444, 0, 0, 0, 0, 0);
    #1;
    chk("idle_after_pair", {31'h0, arb_busy}, 32'h0);

    // Both requests held continuously: grant pattern.
    @(negedge clk);
    data_req = 1'b1; data_wr = 1'b0; data_addr = 32'h0000_6000;
    inst_req = 1'b1; inst_addr = 32'h1C00_0400;
    for (int g = 0; g < 6; g++) begin
      #1;
`ifdef ARB_STARVE_GUARD_EN
      exp_i = (g == 4);
`else
      exp_i = 1'b0;
`endif
      chk("starve_inst_ack", {31'h0, inst_ack}, {31'h0, exp_i});
      chk("starve_data_ack", {31'h0, data_ack}, {31'h0, ~exp_i});
      set_exp_payload(exp_i, 0, exp_i ? 32'h1C00_0400 : 32'h0000_6000, 32'h0, 4'h0);
      @(negedge clk);
      if (g == 5) begin
        data_req = 1'b0;
        inst_req = 1'b0;
      end
      slave(exp_i, 0, 32'h0000_A000 + 32'(g), 0, 0, 0, 0, 0);
    end
    #1;
    chk("idle_after_starve", {31'h0, arb_busy}, 32'h0);

    repeat (2) @(negedge clk);
    chk("sb_drained", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
